pipe_ctrl: RTL and testbench

//  Pipeline control unit for the 5-stage Y86-64 core. Detects load/use, ret and mispredict hazards
//  and drives the stall/bubble inputs of the F/D/E/M/W pipeline registers. A 4-state FSM handles

---
 rtl/pipe_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline control unit for the 5-stage Y86-64 core. Detects
//               load/use, ret and mispredict hazards and drives the
//               stall/bubble controls of the F/D/E/M/W pipeline registers.
//               A 4-state FSM (RUN/DRAIN/PAUSED/HALTED) handles the debug
//               pause drain with req/ack handshake and a sticky halt when an
//               exception reaches write-back.
// Optional    : `PIPE_PERF_EN adds saturating performance counters
//               (cycles, F-stall cycles, mispredicted jumps). Without it the
//               counter outputs are tied to zero.
// Ports       : clk_i/rstn_i           clock, async active-low reset
//               D_/E_/M_ icode, d_src, E_dstM, e_cnd, m_stat, W_stat
//                                      hazard-detection inputs
//               dbg_halt_req_i/ack_o   debug pause handshake
//               F/D_stall, D/E/M_bubble, W_stall
//                                      pipeline register controls
//               state_o                0 RUN, 1 DRAIN, 2 PAUSED, 3 HALTED
//               *_cnt_o                performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_cnd_i,
  input  logic [3:0]       M_icode_i,
  input  logic [3:0]       m_stat_i,
  input  logic [3:0]       W_stat_i,
  input  logic             dbg_halt_req_i,
  output logic             dbg_halt_ack_o,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             W_stall_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam logic [3:0] C_IMRMOVQ = 4'h5;
  localparam logic [3:0] C_IJXX    = 4'h7;
  localparam logic [3:0] C_IRET    = 4'h9;
  localparam logic [3:0] C_IPOPQ   = 4'hB;
  localparam logic [3:0] C_RNONE   = 4'hF;
  localparam logic [3:0] C_SAOK    = 4'h1;

  localparam int               DCNT_W    = $clog2(DRAIN_CYC + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_PAUSED = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t            r_state;
  logic [DCNT_W-1:0] r_dcnt;
  logic              r_ack;

  logic w_lu, w_ret, w_mp, w_exm, w_exw;

  // Hazard terms
  assign w_lu  = ((E_icode_i == C_IMRMOVQ) || (E_icode_i == C_IPOPQ)) &&
                 (E_dstM_i != C_RNONE) &&
                 ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  assign w_ret = (D_icode_i == C_IRET) || (E_icode_i == C_IRET) ||
                 (M_icode_i == C_IRET);
  assign w_mp  = (E_icode_i == C_IJXX) && !e_cnd_i;
  assign w_exm = (m_stat_i != C_SAOK);
  assign w_exw = (W_stat_i != C_SAOK);

  // Pipeline-register controls, zero latency from state and inputs
  always_comb begin
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;
    W_stall_o  = 1'b0;
    case (r_state)
      S_RUN: begin
        F_stall_o  = w_lu | w_ret;
        D_stall_o  = w_lu;
        // A load/use stall holds D, so the ret bubble must wait for it
        D_bubble_o = w_mp | (w_ret & ~w_lu);
        E_bubble_o = w_mp | w_lu;
        M_bubble_o = w_exm | w_exw;
        W_stall_o  = w_exw;
      end
      S_DRAIN: begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_bubble_o = 1'b1;
        M_bubble_o = w_exm | w_exw;
        W_stall_o  = w_exw;
      end
      S_PAUSED: begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_bubble_o = 1'b1;
      end
      default: begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_bubble_o = 1'b1;
        M_bubble_o = 1'b1;
        W_stall_o  = 1'b1;
      end
    endcase
  end

  // Control FSM; an exception in write-back overrides any pause activity
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_RUN;
      r_dcnt  <= '0;
      r_ack   <= 1'b0;
    end else if (w_exw) begin
      r_state <= S_HALTED;
      r_dcnt  <= '0;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_dcnt <= '0;
          // Only start draining once no hazard is redirecting the front end
          if (dbg_halt_req_i && !w_lu && !w_ret && !w_mp) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!dbg_halt_req_i) begin
            r_state <= S_RUN;
            r_dcnt  <= '0;
          end else if (r_dcnt == DCNT_LAST) begin
            r_state <= S_PAUSED;
            r_dcnt  <= '0;
            r_ack   <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_PAUSED: begin
          if (!dbg_halt_req_i) begin
            r_state <= S_RUN;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_HALTED;
        end
      endcase
    end
  end

  assign state_o        = r_state;
  assign dbg_halt_ack_o = r_ack;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] r_cyc_cnt, r_stall_cnt, r_mispred_cnt;

  // Saturating counters, frozen once the core has halted
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cyc_cnt     <= '0;
      r_stall_cnt   <= '0;
      r_mispred_cnt <= '0;
    end else if (r_state != S_HALTED) begin
      if (r_cyc_cnt != '1) r_cyc_cnt <= r_cyc_cnt + 1'b1;
      if (F_stall_o && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if ((r_state == S_RUN) && w_mp && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
    end
  end

  assign cyc_cnt_o     = r_cyc_cnt;
  assign stall_cnt_o   = r_stall_cnt;
  assign mispred_cnt_o = r_mispred_cnt;
`else
  assign cyc_cnt_o     = '0;
  assign stall_cnt_o   = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl. Table of single-cycle RUN
//               hazard vectors plus hand-written drain/pause/halt/reset
//               sequences; expected outputs queue up as stimulus is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int CNT_W = 32;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic [3:0]       D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i;
  logic             e_cnd_i;
  logic [3:0]       M_icode_i, m_stat_i, W_stat_i;
  logic             dbg_halt_req_i;
  logic             dbg_halt_ack_o;
  logic             F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] cyc_cnt_o, stall_cnt_o, mispred_cnt_o;

  pipe_ctrl #(.DRAIN_CYC(3), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .D_icode_i     (D_icode_i),
    .d_srcA_i      (d_srcA_i),
    .d_srcB_i      (d_srcB_i),
    .E_icode_i     (E_icode_i),
    .E_dstM_i      (E_dstM_i),
    .e_cnd_i       (e_cnd_i),
    .M_icode_i     (M_icode_i),
    .m_stat_i      (m_stat_i),
    .W_stat_i      (W_stat_i),
    .dbg_halt_req_i(dbg_halt_req_i),
    .dbg_halt_ack_o(dbg_halt_ack_o),
    .F_stall_o     (F_stall_o),
    .D_stall_o     (D_stall_o),
    .D_bubble_o    (D_bubble_o),
    .E_bubble_o    (E_bubble_o),
    .M_bubble_o    (M_bubble_o),
    .W_stall_o     (W_stall_o),
    .state_o       (state_o),
    .cyc_cnt_o     (cyc_cnt_o),
    .stall_cnt_o   (stall_cnt_o),
    .mispred_cnt_o (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected output word: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, ack, state[1:0]}
  localparam logic [8:0] O_CLEAN  = 9'b000000000;
  localparam logic [8:0] O_LU     = 9'b110100000;
  localparam logic [8:0] O_MP     = 9'b001100000;
  localparam logic [8:0] O_RET    = 9'b101000000;
  localparam logic [8:0] O_EXM    = 9'b000010000;
  localparam logic [8:0] O_DRAIN  = 9'b110100001;
  localparam logic [8:0] O_DRNEXW = 9'b110111001;
  localparam logic [8:0] O_PAUSED = 9'b110100110;
  localparam logic [8:0] O_HALTED = 9'b110111011;

  typedef struct {
    logic [3:0] d_icode, srca, srcb, e_icode, e_dstm;
    logic       cnd;
    logic [3:0] m_icode, m_stat;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs[12];
  logic [8:0] exp_q[$];
  string      name_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [8:0] outs();
    return {F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o,
            dbg_halt_ack_o, state_o};
  endfunction

  task automatic check_pop();
    logic [8:0] e;
    string      n;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    n_cmp++;
    if (outs() !== e) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", n, outs(), e);
    end
  endtask

  task automatic cmp_cnt(input string n, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", n, act, e);
    end
  endtask

  task automatic set_clean();
    D_icode_i = 4'h1; d_srcA_i = 4'hF; d_srcB_i = 4'hF;
    E_icode_i = 4'h1; E_dstM_i = 4'hF; e_cnd_i = 1'b1;
    M_icode_i = 4'h1; m_stat_i = 4'h1; W_stat_i = 4'h1;
  endtask

  // Inputs are already driven; compare mid-cycle, then advance past the next edge
  task automatic go(input logic [8:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk_i);
    check_pop();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    int mp_m, stall_m;
    logic lu, rt;

    //               D     sA    sB    E     dstM  cnd   M     mstat exp       name
    vecs[0]  = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h1, O_CLEAN, "clean"};
    vecs[1]  = '{4'h6, 4'h3, 4'h2, 4'h5, 4'h3, 1'b1, 4'h1, 4'h1, O_LU,    "lu_mrmov_srcA"};
    vecs[2]  = '{4'h6, 4'h1, 4'h4, 4'hB, 4'h4, 1'b1, 4'h1, 4'h1, O_LU,    "lu_popq_srcB"};
    vecs[3]  = '{4'h6, 4'hF, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 4'h1, O_CLEAN, "lu_rnone"};
    vecs[4]  = '{4'h6, 4'h2, 4'h5, 4'h5, 4'h3, 1'b1, 4'h1, 4'h1, O_CLEAN, "lu_nomatch"};
    vecs[5]  = '{4'h6, 4'h3, 4'h3, 4'h6, 4'h3, 1'b1, 4'h1, 4'h1, O_CLEAN, "opq_noload"};
    vecs[6]  = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 4'h1, O_MP,    "mispredict"};
    vecs[7]  = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 4'h1, O_CLEAN, "jump_taken"};
    vecs[8]  = '{4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1'b1, 4'h1, 4'h1, O_RET,   "ret_in_E"};
    vecs[9]  = '{4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 4'h1, O_LU,    "ret_with_lu"};
    vecs[10] = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h3, O_EXM,   "exM_sadr"};
    vecs[11] = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h2, O_EXM,   "exM_shlt"};

    set_clean();
    dbg_halt_req_i = 1'b0;
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    exp_q.push_back(O_CLEAN); name_q.push_back("reset_state");
    check_pop();
    rstn_i = 1'b1;

    for (int i = 0; i < 12; i++) begin
      D_icode_i = vecs[i].d_icode; d_srcA_i = vecs[i].srca; d_srcB_i = vecs[i].srcb;
      E_icode_i = vecs[i].e_icode; E_dstM_i = vecs[i].e_dstm; e_cnd_i = vecs[i].cnd;
      M_icode_i = vecs[i].m_icode; m_stat_i = vecs[i].m_stat;
      go(vecs[i].exp, vecs[i].name);
    end

    // Load/use lasts one cycle: the bubble then sits in E
    set_clean(); E_icode_i = 4'h5; E_dstM_i = 4'h3; d_srcA_i = 4'h3; D_icode_i = 4'h6;
    go(O_LU, "lu_seq_c0");
    set_clean(); D_icode_i = 4'h6; d_srcA_i = 4'h3; E_icode_i = 4'h1;
    go(O_CLEAN, "lu_seq_c1");

    // ret walking down D, E, M
    set_clean(); D_icode_i = 4'h9; go(O_RET, "ret_D");
    set_clean(); E_icode_i = 4'h9; go(O_RET, "ret_E");
    set_clean(); M_icode_i = 4'h9; go(O_RET, "ret_M");
    set_clean(); go(O_CLEAN, "ret_clear");

    // Pause request held off by a mispredict, then full drain/pause/resume
    set_clean(); E_icode_i = 4'h7; e_cnd_i = 1'b0; dbg_halt_req_i = 1'b1;
    go(O_MP, "req_pending_mp");
    set_clean(); go(O_CLEAN, "req_accept");
    go(O_DRAIN, "drain_1");
    go(O_DRAIN, "drain_2");
    go(O_DRAIN, "drain_3");
    m_stat_i = 4'h3;
    go(O_PAUSED, "paused_exM_masked");
    set_clean(); dbg_halt_req_i = 1'b0;
    go(O_PAUSED, "paused_release");
    go(O_CLEAN, "resumed_run");

    // Drain abort, then a fresh drain must take the full count again
    dbg_halt_req_i = 1'b1;
    go(O_CLEAN, "abort_req");
    go(O_DRAIN, "abort_drain_1");
    dbg_halt_req_i = 1'b0;
    go(O_DRAIN, "abort_drop");
    go(O_CLEAN, "abort_run");
    dbg_halt_req_i = 1'b1;
    go(O_CLEAN, "redrain_req");
    go(O_DRAIN, "redrain_1");
    go(O_DRAIN, "redrain_2");
    go(O_DRAIN, "redrain_3");
    go(O_PAUSED, "redrain_paused");
    dbg_halt_req_i = 1'b0;
    go(O_PAUSED, "redrain_release");
    go(O_CLEAN, "redrain_run");

    // Exception in write-back during DRAIN -> sticky HALTED
    dbg_halt_req_i = 1'b1;
    go(O_CLEAN, "halt_req");
    go(O_DRAIN, "halt_drain_1");
    W_stat_i = 4'h3;
    go(O_DRNEXW, "drain_exW");
    set_clean(); dbg_halt_req_i = 1'b0;
    go(O_HALTED, "halted");
    go(O_HALTED, "halted_sticky");

    // Asynchronous reset mid-cycle
    rstn_i = 1'b0;
    #1;
    exp_q.push_back(O_CLEAN); name_q.push_back("async_reset");
    check_pop();
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;

    // Random RUN traffic for the counters
    mp_m = 0; stall_m = 0;
    for (int i = 0; i < 100; i++) begin
      D_icode_i = 4'($urandom_range(0, 11));
      d_srcA_i  = 4'($urandom_range(0, 15));
      d_srcB_i  = 4'($urandom_range(0, 15));
      E_icode_i = 4'($urandom_range(0, 11));
      E_dstM_i  = 4'($urandom_range(0, 15));
      e_cnd_i   = 1'($urandom_range(0, 1));
      M_icode_i = 4'($urandom_range(0, 11));
      m_stat_i  = 4'($urandom_range(1, 4));
      lu = ((E_icode_i == 4'h5) || (E_icode_i == 4'hB)) && (E_dstM_i != 4'hF) &&
           ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
      rt = (D_icode_i == 4'h9) || (E_icode_i == 4'h9) || (M_icode_i == 4'h9);
      if ((E_icode_i == 4'h7) && !e_cnd_i) mp_m++;
      if (lu || rt) stall_m++;
      @(posedge clk_i);
      #1;
    end
`ifdef PIPE_PERF_EN
    cmp_cnt("cyc_cnt", cyc_cnt_o, 32'd100);
    cmp_cnt("stall_cnt", stall_cnt_o, CNT_W'(stall_m));
    cmp_cnt("mispred_cnt", mispred_cnt_o, CNT_W'(mp_m));
`else
    cmp_cnt("cyc_cnt", cyc_cnt_o, '0);
    cmp_cnt("stall_cnt", stall_cnt_o, '0);
    cmp_cnt("mispred_cnt", mispred_cnt_o, '0);
`endif
    set_clean();
    go(O_CLEAN, "post_traffic_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
